io_controller: RTL and testbench

Memory-mapped-free I/O stage directly downstream of the core's I/O port: it buffers UART receive bytes and assembles them into 32-bit words on core input requests, and it splits core output words into bytes queued for the UART transmitter. It generates `io_stall` to hold the core while an input word is unavailable or the transmit queue lacks room. It sits between the core top and the UART RX/TX byte engines.

---
 rtl/io_controller_if.sv | 26 ++
 rtl/io_controller.sv | 171 +++++++++++++++++
 tb/tb_io_controller.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/io_controller_if.sv
// Core/UART-facing signal bundle for io_controller.
// slave is the controller's view, master is the driving environment.
interface io_controller_if;
  logic        input_req;
  logic [31:0] input_data;
  logic        input_valid;
  logic [31:0] output_data;
  logic        output_valid;
  logic        io_stall;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic        rx_overrun;

  modport slave (
    input  input_req, output_data, output_valid, rx_data, rx_valid, tx_busy,
    output input_data, input_valid, io_stall, tx_data, tx_start, rx_overrun
  );

  modport master (
    output input_req, output_data, output_valid, rx_data, rx_valid, tx_busy,
    input  input_data, input_valid, io_stall, tx_data, tx_start, rx_overrun
  );
endinterface

// File: rtl/io_controller.sv
// I/O stage: buffers UART RX bytes into little-endian 32-bit input words and
// splits core output words into a byte queue feeding the UART transmitter.
module io_controller #(
  parameter int unsigned RX_DEPTH = 16,
  parameter int unsigned TX_DEPTH = 16
) (
  input  logic           clk,
  input  logic           rstn,
  io_controller_if.slave io
);
  localparam int unsigned RXAW = $clog2(RX_DEPTH);
  localparam int unsigned RXCW = RXAW + 1;
  localparam int unsigned TXAW = $clog2(TX_DEPTH);
  localparam int unsigned TXCW = TXAW + 1;
  localparam logic [RXCW-1:0] RX_FULL = RXCW'(RX_DEPTH);
  localparam logic [RXCW-1:0] RX_WORD = RXCW'(4);
  localparam logic [TXCW-1:0] TX_FULL = TXCW'(TX_DEPTH);
  localparam logic [TXCW-1:0] TX_WORD = TXCW'(4);

  typedef enum logic [1:0] {IN_IDLE, IN_WAIT, IN_ACK} in_state_e;
  typedef enum logic       {TX_IDLE, TX_GUARD}        tx_state_e;

  // ---------------- RX FIFO ----------------
  logic [7:0]      rx_mem_q [RX_DEPTH];
  logic [RXAW-1:0] rx_wr_q, rx_rd_q;
  logic [RXCW-1:0] rx_cnt_q, rx_cnt_d;
  logic            rx_overrun_q;
  logic            rx_push, rx_pop;
  logic [31:0]     rx_word;

  in_state_e       in_state_q;
  logic            in_valid_q;
  logic [31:0]     in_data_q;

  assign rx_pop  = (in_state_q == IN_WAIT) && (rx_cnt_q >= RX_WORD);
  // A full FIFO still takes a byte when four are leaving in the same cycle.
  assign rx_push = io.rx_valid && ((rx_cnt_q < RX_FULL) || rx_pop);
  assign rx_word = {rx_mem_q[rx_rd_q + RXAW'(3)], rx_mem_q[rx_rd_q + RXAW'(2)],
                    rx_mem_q[rx_rd_q + RXAW'(1)], rx_mem_q[rx_rd_q]};

  always_comb begin
    rx_cnt_d = rx_cnt_q;
    if (rx_push) rx_cnt_d = rx_cnt_d + RXCW'(1);
    if (rx_pop)  rx_cnt_d = rx_cnt_d - RX_WORD;
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem_q[rx_wr_q] <= io.rx_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_wr_q      <= '0;
      rx_rd_q      <= '0;
      rx_cnt_q     <= '0;
      rx_overrun_q <= 1'b0;
    end else begin
      rx_cnt_q <= rx_cnt_d;
      if (rx_push) rx_wr_q <= rx_wr_q + RXAW'(1);
      if (rx_pop)  rx_rd_q <= rx_rd_q + RXAW'(4);
      if (io.rx_valid && !rx_push) rx_overrun_q <= 1'b1;
    end
  end

  // ---------------- Input FSM ----------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      in_state_q <= IN_IDLE;
      in_valid_q <= 1'b0;
      in_data_q  <= '0;
    end else begin
      case (in_state_q)
        IN_IDLE: begin
          in_valid_q <= 1'b0;
          if (io.input_req) in_state_q <= IN_WAIT;
        end
        IN_WAIT: begin
          if (rx_pop) begin
            in_data_q  <= rx_word;
            in_valid_q <= 1'b1;
            in_state_q <= IN_ACK;
          end
        end
        IN_ACK: begin
          in_valid_q <= 1'b0;
          in_state_q <= IN_IDLE;
        end
        default: begin
          in_valid_q <= 1'b0;
          in_state_q <= IN_IDLE;
        end
      endcase
    end
  end

  // ---------------- TX FIFO ----------------
  logic [7:0]      tx_mem_q [TX_DEPTH];
  logic [TXAW-1:0] tx_wr_q, tx_rd_q;
  logic [TXCW-1:0] tx_cnt_q, tx_cnt_d, tx_free;
  logic            tx_accept, tx_pop;
  tx_state_e       tx_state_q;
  logic            tx_start_q;
  logic [7:0]      tx_data_q;

  // Room is judged on the registered count, before this cycle's drain.
  assign tx_free   = TX_FULL - tx_cnt_q;
  assign tx_accept = io.output_valid && (tx_free >= TX_WORD);
  assign tx_pop    = (tx_state_q == TX_IDLE) && (tx_cnt_q != '0) && !io.tx_busy;

  always_comb begin
    tx_cnt_d = tx_cnt_q;
    if (tx_accept) tx_cnt_d = tx_cnt_d + TX_WORD;
    if (tx_pop)    tx_cnt_d = tx_cnt_d - TXCW'(1);
  end

  always_ff @(posedge clk) begin
    if (tx_accept) begin
      for (int unsigned k = 0; k < 4; k++) begin
        tx_mem_q[tx_wr_q + TXAW'(k)] <= io.output_data[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_wr_q  <= '0;
      tx_rd_q  <= '0;
      tx_cnt_q <= '0;
    end else begin
      tx_cnt_q <= tx_cnt_d;
      if (tx_accept) tx_wr_q <= tx_wr_q + TXAW'(4);
      if (tx_pop)    tx_rd_q <= tx_rd_q + TXAW'(1);
    end
  end

  // ---------------- TX drain FSM ----------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_state_q <= TX_IDLE;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      case (tx_state_q)
        TX_IDLE: begin
          tx_start_q <= 1'b0;
          if (tx_pop) begin
            tx_data_q  <= tx_mem_q[tx_rd_q];
            tx_start_q <= 1'b1;
            tx_state_q <= TX_GUARD;
          end
        end
        TX_GUARD: begin
          tx_start_q <= 1'b0;
          tx_state_q <= TX_IDLE;
        end
        default: begin
          tx_start_q <= 1'b0;
          tx_state_q <= TX_IDLE;
        end
      endcase
    end
  end

  // ---------------- Outputs ----------------
  assign io.input_data  = in_data_q;
  assign io.input_valid = in_valid_q;
  assign io.tx_data     = tx_data_q;
  assign io.tx_start    = tx_start_q;
  assign io.rx_overrun  = rx_overrun_q;
  assign io.io_stall    = (io.input_req & ~in_valid_q) | (io.output_valid & (tx_free < TX_WORD));
endmodule

// File: tb/tb_io_controller.sv
// Directed bench for io_controller: queue-based reference model checked every
// cycle, plus hand-computed literal expectations for each scenario.
module tb_io_controller;
  localparam int unsigned RXD = 16;
  localparam int unsigned TXD = 16;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  io_controller_if bus ();

  io_controller #(.RX_DEPTH(RXD), .TX_DEPTH(TXD)) dut (
    .clk  (clk),
    .rstn (rstn),
    .io   (bus)
  );

  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  rxq[$];
  logic [7:0]  txq[$];
  logic [7:0]  tx_log[$];
  bit          m_ovr, m_latched, m_valid, m_start;
  logic [31:0] m_word;
  logic [7:0]  m_txd;

  initial begin
    forever begin
      @(negedge clk); #4;
      if (!rstn) begin
        rxq.delete(); txq.delete();
        m_ovr = 0; m_latched = 0; m_valid = 0; m_start = 0; m_txd = '0;
      end
      check("input_valid", bus.input_valid, {31'd0, m_valid});
      if (m_valid) check("input_data", bus.input_data, m_word);
      check("io_stall", bus.io_stall,
            {31'd0, (bus.input_req && !m_valid) ||
                    (bus.output_valid && (int'(TXD) - txq.size()) < 4)});
      check("tx_start", bus.tx_start, {31'd0, m_start});
      check("tx_data", {24'd0, bus.tx_data}, {24'd0, m_txd});
      check("rx_overrun", bus.rx_overrun, {31'd0, m_ovr});
      if (bus.tx_start) tx_log.push_back(bus.tx_data);
      if (rstn) begin
        bit was_full, took4, acc, nv, nl, ns;
        was_full = rxq.size() >= int'(RXD);
        took4 = 0;
        nv = 0; nl = 0;
        if (m_valid) begin
          nl = 0;
        end else if (!m_latched) begin
          nl = bus.input_req;
        end else if (rxq.size() >= 4) begin
          m_word = {rxq[3], rxq[2], rxq[1], rxq[0]};
          repeat (4) void'(rxq.pop_front());
          took4 = 1; nv = 1;
        end else begin
          nl = 1;
        end
        m_valid = nv; m_latched = nl;
        if (bus.rx_valid) begin
          if (!was_full || took4) rxq.push_back(bus.rx_data);
          else m_ovr = 1;
        end
        acc = bus.output_valid && (int'(TXD) - txq.size()) >= 4;
        ns = 0;
        if (!m_start && txq.size() > 0 && !bus.tx_busy) begin
          m_txd = txq.pop_front();
          ns = 1;
        end
        m_start = ns;
        if (acc) for (int k = 0; k < 4; k++) txq.push_back(bus.output_data[8*k +: 8]);
      end
    end
  end

  // ---------------- transmitter busy emulation ----------------
  int busy_mode = 0;  // 0: idle, 1: busy 10 cycles after each start, 2: stuck busy
  initial begin
    int cnt = 0;
    bus.tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      case (busy_mode)
        1: begin
          if (bus.tx_start) cnt = 10;
          bus.tx_busy = (cnt > 0);
          if (cnt > 0) cnt--;
        end
        2:       bus.tx_busy = 1'b1;
        default: begin bus.tx_busy = 1'b0; cnt = 0; end
      endcase
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic push_rx(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    cyc();
    bus.rx_valid = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ivalid"},  bus.input_valid, 0);
    check({tag, "_idata"},   bus.input_data, 0);
    check({tag, "_txdata"},  {24'd0, bus.tx_data}, 0);
    check({tag, "_txstart"}, bus.tx_start, 0);
    check({tag, "_ovr"},     bus.rx_overrun, 0);
  endtask

  // Request already raised in the current cycle; stall must hold until delivery.
  task automatic wait_word(input string name, input logic [31:0] exp);
    bit got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      #4;
      if (bus.input_valid) begin
        got = 1;
        check(name, bus.input_data, exp);
      end else begin
        check({name, "_stall"}, bus.io_stall, 1);
      end
      cyc();
    end
    if (!got) check({name, "_timeout"}, 0, 1);
    bus.input_req = 1'b0;
    cyc();
  endtask

  task automatic do_word(input string name, input logic [31:0] exp);
    bus.input_req = 1'b1;
    wait_word(name, exp);
  endtask

  task automatic wait_log(input int n, input string name);
    for (int i = 0; i < 200 && tx_log.size() < n; i++) cyc();
    check(name, tx_log.size() >= n, 1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [7:0] ser [4];
    int base, seen;
    bus.input_req = 0; bus.output_data = '0; bus.output_valid = 0;
    bus.rx_data = '0; bus.rx_valid = 0;

    // power-on reset
    cyc(); #4;
    check_outputs_zero("por");
    cyc(); rstn = 1'b1; cyc();

    // input assembly
    push_rx(8'h11); push_rx(8'h22); push_rx(8'h33); push_rx(8'h44);
    bus.input_req = 1'b1;
    #4; check("asm_c0_stall", bus.io_stall, 1); check("asm_c0_valid", bus.input_valid, 0);
    cyc(); #4; check("asm_c1_stall", bus.io_stall, 1);
    cyc(); #4;
    check("asm_valid", bus.input_valid, 1);
    check("asm_data", bus.input_data, 32'h44332211);
    check("asm_stall_low", bus.io_stall, 0);
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(); #4;
      if (bus.input_valid) seen++;
    end
    check("held_req_one_pulse", seen, 0);
    cyc(); bus.input_req = 1'b0; cyc();

    // output serialization with a slow transmitter
    busy_mode = 1;
    base = tx_log.size();
    bus.output_data = 32'hDEADBEEF; bus.output_valid = 1'b1;
    #4; check("ser_accept_stall", bus.io_stall, 0);
    cyc(); bus.output_valid = 1'b0;
    wait_log(base + 4, "ser_done");
    ser = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    for (int i = 0; i < 4; i++)
      if (tx_log.size() > base + i) check("ser_byte", {24'd0, tx_log[base+i]}, {24'd0, ser[i]});
    for (int i = 0; i < 12; i++) cyc();

    // TX full with stuck transmitter, then drain
    busy_mode = 2; cyc(); cyc();
    base = tx_log.size();
    for (int w = 0; w < 4; w++) begin
      bus.output_data = {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)};
      bus.output_valid = 1'b1;
      #4; check("fill_stall", bus.io_stall, 0);
      cyc();
    end
    bus.output_data = 32'h13121110;
    #4; check("full_stall0", bus.io_stall, 1);
    cyc(); #4; check("full_stall1", bus.io_stall, 1);
    cyc(); busy_mode = 0;
    seen = 0;
    for (int i = 0; i < 40 && seen == 0; i++) begin
      #4;
      if (!bus.io_stall) seen = 1;
      cyc();
    end
    check("full_accepted", seen, 1);
    bus.output_valid = 1'b0;
    check("full_drained_before_accept", tx_log.size() - base, 4);
    wait_log(base + 20, "full_done");
    for (int i = 0; i < 20; i++)
      if (tx_log.size() > base + i) check("full_order", {24'd0, tx_log[base+i]}, i);
    cyc();

    // reset mid-transfer with 3 bytes buffered and a request pending
    push_rx(8'h91); push_rx(8'h92); push_rx(8'h93);
    bus.input_req = 1'b1;
    rstn = 1'b0;
    #4; check_outputs_zero("rst");
    check("rst_stall_follows_req", bus.io_stall, 1);
    cyc(); cyc(); rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #4; check("post_rst_stall", bus.io_stall, 1);
      cyc();
    end
    push_rx(8'hA1); push_rx(8'hA2); push_rx(8'hA3); push_rx(8'hA4);
    wait_word("post_rst_word", 32'hA4A3A2A1);

    // starved input
    push_rx(8'hB1); push_rx(8'hB2);
    bus.input_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #4; check("starved_stall", bus.io_stall, 1);
      cyc();
    end
    push_rx(8'hB3); push_rx(8'hB4);
    wait_word("starved_word", 32'hB4B3B2B1);

    // RX overrun, then pop concurrent with push on a full FIFO
    for (int i = 0; i < 17; i++) push_rx(8'(8'h40 + i));
    #4; check("overrun_set", bus.rx_overrun, 1);
    cyc();
    bus.input_req = 1'b1;
    cyc();
    bus.rx_data = 8'h77; bus.rx_valid = 1'b1;
    cyc();
    bus.rx_valid = 1'b0;
    #4;
    check("ovr_word0_valid", bus.input_valid, 1);
    check("ovr_word0", bus.input_data, 32'h43424140);
    cyc(); bus.input_req = 1'b0; cyc();
    do_word("ovr_word1", 32'h47464544);
    do_word("ovr_word2", 32'h4B4A4948);
    do_word("ovr_word3", 32'h4F4E4D4C);
    push_rx(8'h78); push_rx(8'h79); push_rx(8'h7A);
    do_word("ovr_word4", 32'h7A797877);
    #4; check("overrun_sticky", bus.rx_overrun, 1);
    cyc();

    // reset clears the sticky flag
    rstn = 1'b0;
    #4; check("final_rst_ovr", bus.rx_overrun, 0);
    cyc(); rstn = 1'b1; cyc(); cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
